// File: rtl/vga_timing_gen_pkg.sv
// Shared widths, timing defaults and the packed pixel-beat payload for the VGA timing generator.
package vga_timing_gen_pkg;

  localparam int unsigned CNT_W    = 10;
  localparam int unsigned FC_W     = 8;
  localparam int unsigned VPART2_W = 9;

  // 640x480@60 defaults (800x525 total)
  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_H_FP     = 16;
  localparam int unsigned DEF_H_SYNC   = 96;
  localparam int unsigned DEF_H_BP     = 48;
  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_V_FP     = 10;
  localparam int unsigned DEF_V_SYNC   = 2;
  localparam int unsigned DEF_V_BP     = 33;

  typedef struct packed {
    logic [VPART2_W-1:0] vpart2;
    logic                activevideo;
    logic [CNT_W-1:0]    y_px;
    logic [CNT_W-1:0]    x_px;
    logic                vsync;
    logic                hsync;
  } stream_t;

  // Inclusive window test used for the sync pulse decode.
  function automatic logic in_window(input logic [CNT_W-1:0] c,
                                     input logic [CNT_W-1:0] lo,
                                     input logic [CNT_W-1:0] hi);
    return (c >= lo) && (c <= hi);
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Pixel-beat output bundle of the VGA timing generator.
interface vga_timing_gen_if;
  import vga_timing_gen_pkg::*;

  stream_t          out;
  logic             hsync;
  logic             vsync;
  logic [CNT_W-1:0] x_px;
  logic [CNT_W-1:0] y_px;
  logic             activevideo;
  logic             frame_end;
  logic [FC_W-1:0]  frame_cnt;

  modport master (
    output out, hsync, vsync, x_px, y_px, activevideo, frame_end, frame_cnt
  );

  modport slave (
    input out, hsync, vsync, x_px, y_px, activevideo, frame_end, frame_cnt
  );

endinterface

// File: rtl/wrap_counter.sv
// Enable-gated up counter that wraps MAX -> 0; wrap flags the enabled cycle at MAX.
module wrap_counter #(
  parameter int unsigned W   = 10,
  parameter int unsigned MAX = 799
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count,
  output logic         wrap
);

  localparam logic [W-1:0] MAX_L = W'(MAX);

  assign wrap = inc && (count == MAX_L);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc) begin
      count <= wrap ? '0 : count + W'(1);
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Registered VGA timing generator: position counters, sync/active decode, frame strobe and counter.
module vga_timing_gen
  import vga_timing_gen_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP,
  parameter logic        SYNC_POL = 1'b0
) (
  input  logic              px_clk,
  input  logic              rst_n,
  vga_timing_gen_if.master  bus
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_ACT_LAST = CNT_W'(H_ACTIVE - 1);
  localparam logic [CNT_W-1:0] V_ACT_LAST = CNT_W'(V_ACTIVE - 1);
  localparam logic [CNT_W-1:0] HS_FIRST   = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_LAST    = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CNT_W-1:0] VS_FIRST   = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_LAST    = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);

  // Both totals must fit the 10-bit position counters.
  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_total_check
    $error("vga_timing_gen: H_TOTAL/V_TOTAL exceed 1024");
  end

  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;
  logic             h_wrap;
  logic             v_wrap;

  wrap_counter #(
    .W   (CNT_W),
    .MAX (H_TOTAL - 1)
  ) u_h_cnt (
    .clk   (px_clk),
    .rst_n (rst_n),
    .inc   (1'b1),
    .count (h_cnt),
    .wrap  (h_wrap)
  );

  wrap_counter #(
    .W   (CNT_W),
    .MAX (V_TOTAL - 1)
  ) u_v_cnt (
    .clk   (px_clk),
    .rst_n (rst_n),
    .inc   (h_wrap),
    .count (v_cnt),
    .wrap  (v_wrap)
  );

  logic active_c;
  logic hsync_c;
  logic vsync_c;
  logic frame_end_c;

  // Decode of the current counter state, captured on the same edge the counters advance.
  always_comb begin
    active_c    = (h_cnt <= H_ACT_LAST) && (v_cnt <= V_ACT_LAST);
    hsync_c     = in_window(h_cnt, HS_FIRST, HS_LAST) ? SYNC_POL : ~SYNC_POL;
    vsync_c     = in_window(v_cnt, VS_FIRST, VS_LAST) ? SYNC_POL : ~SYNC_POL;
    frame_end_c = (h_cnt == H_ACT_LAST) && (v_cnt == V_ACT_LAST);
  end

  logic [CNT_W-1:0] x_q;
  logic [CNT_W-1:0] y_q;
  logic             active_q;
  logic             hsync_q;
  logic             vsync_q;
  logic             frame_end_q;
  logic [FC_W-1:0]  frame_cnt_q;

  always_ff @(posedge px_clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q         <= '0;
      y_q         <= '0;
      active_q    <= 1'b0;
      hsync_q     <= ~SYNC_POL;
      vsync_q     <= ~SYNC_POL;
      frame_end_q <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      x_q         <= h_cnt;
      y_q         <= v_cnt;
      active_q    <= active_c;
      hsync_q     <= hsync_c;
      vsync_q     <= vsync_c;
      frame_end_q <= frame_end_c;
      // v_wrap is high exactly while the last beat of the frame is being registered.
      if (v_wrap) begin
        frame_cnt_q <= frame_cnt_q + FC_W'(1);
      end
    end
  end

  assign bus.out = '{
    vpart2:      '0,
    activevideo: active_q,
    y_px:        y_q,
    x_px:        x_q,
    vsync:       vsync_q,
    hsync:       hsync_q
  };
  assign bus.hsync       = hsync_q;
  assign bus.vsync       = vsync_q;
  assign bus.x_px        = x_q;
  assign bus.y_px        = y_q;
  assign bus.activevideo = active_q;
  assign bus.frame_end   = frame_end_q;
  assign bus.frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default, mid-size (active-high sync) and tiny instances side by side.
module tb_vga_timing_gen;
  import vga_timing_gen_pkg::*;

  typedef struct packed {
    stream_t     out;
    logic        hsync;
    logic        vsync;
    logic [9:0]  x_px;
    logic [9:0]  y_px;
    logic        activevideo;
    logic        frame_end;
    logic [7:0]  frame_cnt;
  } obs_t;

  typedef struct {
    int k;
    int n;
    int x;
    int y;
    bit act;
    bit hs;
    bit vs;
    bit fe;
    int fc;
  } vec_t;

  localparam int P_HA  [3] = '{640, 16, 4};
  localparam int P_HFP [3] = '{16,  2,  1};
  localparam int P_HS  [3] = '{96,  4,  1};
  localparam int P_HBP [3] = '{48,  2,  1};
  localparam int P_VA  [3] = '{480, 8,  2};
  localparam int P_VFP [3] = '{10,  2,  1};
  localparam int P_VS  [3] = '{2,   2,  1};
  localparam int P_VBP [3] = '{33,  2,  1};
  localparam bit P_POL [3] = '{1'b0, 1'b1, 1'b0};

  logic px_clk = 1'b0;
  logic rst_n  = 1'b0;
  int   tests  = 0;
  int   fails  = 0;

  vga_timing_gen_if bus_def ();
  vga_timing_gen_if bus_mid ();
  vga_timing_gen_if bus_sml ();

  vga_timing_gen u_def (.px_clk(px_clk), .rst_n(rst_n), .bus(bus_def));

  vga_timing_gen #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(2),
    .V_ACTIVE(8),  .V_FP(2), .V_SYNC(2), .V_BP(2),
    .SYNC_POL(1'b1)
  ) u_mid (.px_clk(px_clk), .rst_n(rst_n), .bus(bus_mid));

  vga_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
    .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .SYNC_POL(1'b0)
  ) u_sml (.px_clk(px_clk), .rst_n(rst_n), .bus(bus_sml));

  always #5 px_clk = ~px_clk;

  obs_t dut_obs [3];
  assign dut_obs[0] = {bus_def.out, bus_def.hsync, bus_def.vsync, bus_def.x_px, bus_def.y_px,
                       bus_def.activevideo, bus_def.frame_end, bus_def.frame_cnt};
  assign dut_obs[1] = {bus_mid.out, bus_mid.hsync, bus_mid.vsync, bus_mid.x_px, bus_mid.y_px,
                       bus_mid.activevideo, bus_mid.frame_end, bus_mid.frame_cnt};
  assign dut_obs[2] = {bus_sml.out, bus_sml.hsync, bus_sml.vsync, bus_sml.x_px, bus_sml.y_px,
                       bus_sml.activevideo, bus_sml.frame_end, bus_sml.frame_cnt};

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic obs_t reset_obs(input int k);
    obs_t o;
    o           = '0;
    o.hsync     = ~P_POL[k];
    o.vsync     = ~P_POL[k];
    o.out.hsync = ~P_POL[k];
    o.out.vsync = ~P_POL[k];
    return o;
  endfunction

  function automatic obs_t model_beat(input int k, input int h, input int v, input int fc);
    obs_t o;
    int   hs0;
    int   vs0;
    hs0           = P_HA[k] + P_HFP[k];
    vs0           = P_VA[k] + P_VFP[k];
    o             = '0;
    o.x_px        = 10'(h);
    o.y_px        = 10'(v);
    o.activevideo = (h < P_HA[k]) && (v < P_VA[k]);
    o.hsync       = (h >= hs0 && h < hs0 + P_HS[k]) ? P_POL[k] : ~P_POL[k];
    o.vsync       = (v >= vs0 && v < vs0 + P_VS[k]) ? P_POL[k] : ~P_POL[k];
    o.frame_end   = (h == P_HA[k] - 1) && (v == P_VA[k] - 1);
    o.frame_cnt   = 8'(fc);
    o.out         = '{vpart2: '0, activevideo: o.activevideo, y_px: o.y_px, x_px: o.x_px,
                      vsync: o.vsync, hsync: o.hsync};
    return o;
  endfunction

  // Scoreboard: one expected beat per instance pushed on every clocked edge out of reset.
  int   m_h  [3];
  int   m_v  [3];
  int   m_fc [3];
  obs_t sb_q [3][$];
  int   beat_cnt = 0;

  always @(posedge px_clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 3; k++) begin
        m_h[k]  = 0;
        m_v[k]  = 0;
        m_fc[k] = 0;
        sb_q[k].delete();
      end
      beat_cnt = 0;
    end else begin
      for (int k = 0; k < 3; k++) begin
        int ht;
        int vt;
        ht = P_HA[k] + P_HFP[k] + P_HS[k] + P_HBP[k];
        vt = P_VA[k] + P_VFP[k] + P_VS[k] + P_VBP[k];
        if (m_h[k] == ht - 1 && m_v[k] == vt - 1) m_fc[k] = (m_fc[k] + 1) % 256;
        sb_q[k].push_back(model_beat(k, m_h[k], m_v[k], m_fc[k]));
        m_h[k]++;
        if (m_h[k] == ht) begin
          m_h[k] = 0;
          m_v[k]++;
          if (m_v[k] == vt) m_v[k] = 0;
        end
      end
      beat_cnt++;
    end
  end

  always @(negedge px_clk) begin
    for (int k = 0; k < 3; k++) begin
      if (!rst_n) begin
        check($sformatf("reset_hold[%0d]", k), 64'(dut_obs[k]), 64'(reset_obs(k)));
      end else if (sb_q[k].size() > 0) begin
        obs_t e;
        e = sb_q[k].pop_front();
        check($sformatf("beat[%0d] n=%0d", k, beat_cnt - 1), 64'(dut_obs[k]), 64'(e));
      end
    end
  end

  // Window counters over fixed beat ranges of the first run.
  int hs_low_def   = 0;
  int vs_act_mid   = 0;
  int fe_cnt_mid   = 0;
  int fe_first_mid = -1;
  int fe_second_mid = -1;

  always @(negedge px_clk) begin
    if (rst_n && beat_cnt > 0) begin
      int b;
      b = beat_cnt - 1;
      if (b >= 1600 && b < 2400 && bus_def.hsync == 1'b0) hs_low_def++;
      if (b >= 336 && b < 672) begin
        if (bus_mid.vsync == 1'b1) vs_act_mid++;
        if (bus_mid.frame_end) fe_cnt_mid++;
      end
      if (bus_mid.frame_end) begin
        if (fe_first_mid < 0) fe_first_mid = b;
        else if (fe_second_mid < 0) fe_second_mid = b;
      end
    end
  end

  vec_t tbl[$];

  task automatic add(input int k, input int n, input int x, input int y, input bit act,
                     input bit hs, input bit vs, input bit fe, input int fc);
    vec_t v;
    v = '{k: k, n: n, x: x, y: y, act: act, hs: hs, vs: vs, fe: fe, fc: fc};
    tbl.push_back(v);
  endtask

  task automatic wait_beat(input int n, output bit ok);
    int guard;
    guard = 0;
    ok    = 1'b1;
    while (beat_cnt - 1 < n) begin
      @(negedge px_clk);
      guard++;
      if (guard > 20000) begin
        ok = 1'b0;
        break;
      end
    end
  endtask

  initial begin
    bit ok;

    // k=0 default 800x525, k=1 mid 24x14 active-high, k=2 small 7x5
    add(0, 0,    0,   0, 1, 1, 1, 0, 0);
    add(2, 10,   3,   1, 1, 1, 1, 1, 0);
    add(2, 11,   4,   1, 0, 1, 1, 0, 0);
    add(2, 12,   5,   1, 0, 0, 1, 0, 0);
    add(1, 18,   18,  0, 0, 1, 0, 0, 0);
    add(1, 22,   22,  0, 0, 0, 0, 0, 0);
    add(2, 26,   5,   3, 0, 0, 0, 0, 0);
    add(2, 34,   6,   4, 0, 1, 1, 0, 1);
    add(2, 45,   3,   1, 1, 1, 1, 1, 1);
    add(1, 183,  15,  7, 1, 0, 0, 1, 0);
    add(1, 240,  0,  10, 0, 0, 1, 0, 0);
    add(1, 335,  23, 13, 0, 0, 0, 0, 1);
    add(0, 639,  639, 0, 1, 1, 1, 0, 0);
    add(0, 640,  640, 0, 0, 1, 1, 0, 0);
    add(0, 655,  655, 0, 0, 1, 1, 0, 0);
    add(0, 656,  656, 0, 0, 0, 1, 0, 0);
    add(0, 751,  751, 0, 0, 0, 1, 0, 0);
    add(0, 752,  752, 0, 0, 1, 1, 0, 0);
    add(0, 799,  799, 0, 0, 1, 1, 0, 0);
    add(0, 800,  0,   1, 1, 1, 1, 0, 0);
    add(0, 1599, 799, 1, 0, 1, 1, 0, 0);
    add(0, 1600, 0,   2, 1, 1, 1, 0, 0);
    add(2, 8958, 5,   4, 0, 0, 1, 0, 255);
    add(2, 8959, 6,   4, 0, 1, 1, 0, 0);
    add(2, 8960, 0,   0, 1, 1, 1, 0, 0);

    rst_n = 1'b0;
    repeat (4) @(negedge px_clk);
    check("rst hsync",     64'(bus_def.hsync),       64'(1));
    check("rst vsync",     64'(bus_def.vsync),       64'(1));
    check("rst active",    64'(bus_def.activevideo), 64'(0));
    check("rst frame_cnt", 64'(bus_def.frame_cnt),   64'(0));
    check("rst mid hsync", 64'(bus_mid.hsync),       64'(0));
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      logic [31:0] got;
      logic [31:0] exp;
      wait_beat(tbl[i].n, ok);
      if (!ok) begin
        check($sformatf("timeout vec n=%0d", tbl[i].n), 64'(0), 64'(1));
        break;
      end
      got = {dut_obs[tbl[i].k].x_px, dut_obs[tbl[i].k].y_px, dut_obs[tbl[i].k].activevideo,
             dut_obs[tbl[i].k].hsync, dut_obs[tbl[i].k].vsync, dut_obs[tbl[i].k].frame_end,
             dut_obs[tbl[i].k].frame_cnt};
      exp = {10'(tbl[i].x), 10'(tbl[i].y), tbl[i].act, tbl[i].hs, tbl[i].vs, tbl[i].fe,
             8'(tbl[i].fc)};
      check($sformatf("vec[%0d] inst=%0d n=%0d", i, tbl[i].k, tbl[i].n), 64'(got), 64'(exp));
    end

    wait_beat(9100, ok);
    check("reach 9100", 64'(ok), 64'(1));
    check("hsync low beats line 2", 64'(hs_low_def), 64'(96));
    check("mid vsync beats frame 1", 64'(vs_act_mid), 64'(48));
    check("mid frame_end per frame", 64'(fe_cnt_mid), 64'(1));
    check("mid frame_end first", 64'(fe_first_mid), 64'(183));
    check("mid frame_end period", 64'(fe_second_mid - fe_first_mid), 64'(336));
    check("pre-reset pos", 64'({bus_def.x_px, bus_def.y_px}), 64'({10'd300, 10'd11}));

    // Asynchronous reset mid-line, checked before any further clock edge.
    #2 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("async reset[%0d]", k), 64'(dut_obs[k]), 64'(reset_obs(k)));
    end
    repeat (3) @(negedge px_clk);
    rst_n = 1'b1;

    wait_beat(0, ok);
    check("restart def", 64'({bus_def.x_px, bus_def.y_px, bus_def.activevideo, bus_def.frame_cnt}),
          64'({10'd0, 10'd0, 1'b1, 8'd0}));
    check("restart sml frame_cnt", 64'(bus_sml.frame_cnt), 64'(0));
    wait_beat(40, ok);
    check("restart sml pos", 64'({bus_sml.x_px, bus_sml.y_px, bus_sml.frame_cnt}),
          64'({10'd5, 10'd0, 8'd1}));

    @(negedge px_clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
